// File: rtl/vout_timing_reader_if.sv
// ---------------------------------------------------------------------------
// vout_timing_reader_if
//   Bundles the line-fetch handshake and the read-FIFO pop interface between
//   the video output timing reader and the SDRAM read engine.
//   Signal names are written from the timing reader's point of view.
//
//   o_line_req   reader -> engine   line fetch request, held until acked
//   o_line_num   reader -> engine   frame-buffer line to fetch
//   i_line_ack   engine -> reader   1-clk acceptance pulse
//   i_pxl_valid  engine -> reader   read FIFO not empty
//   i_pxl_data   engine -> reader   {R[3:0],G[3:0],B[3:0],I}
//   o_pxl_rd     reader -> engine   FIFO pop strobe
//
//   master : timing reader side
//   slave  : read engine side
// ---------------------------------------------------------------------------
interface vout_timing_reader_if #(
  parameter int SCR_SIZE_BIT = 10
) ();

  logic                  o_line_req;
  logic [SCR_SIZE_BIT:0] o_line_num;
  logic                  i_line_ack;
  logic                  i_pxl_valid;
  logic [12:0]           i_pxl_data;
  logic                  o_pxl_rd;

  modport master (
    output o_line_req,
    output o_line_num,
    output o_pxl_rd,
    input  i_line_ack,
    input  i_pxl_valid,
    input  i_pxl_data
  );

  modport slave (
    input  o_line_req,
    input  o_line_num,
    input  o_pxl_rd,
    output i_line_ack,
    output i_pxl_valid,
    output i_pxl_data
  );

endinterface : vout_timing_reader_if

// File: rtl/vout_timing_reader.sv
// ---------------------------------------------------------------------------
// vout_timing_reader
//   Display-side video timing generator and frame-buffer drain. Produces
//   HS/VS/DE, requests each active line from the SDRAM read engine ahead of
//   time, pops RGBI pixels from the read FIFO and expands them to 8-bit RGB.
//   Single clock domain (i_vo_clk).
//
// Ports
//   i_vo_clk        video output clock
//   i_reset         asynchronous reset, active-high
//   i_enable        1 = run timing, 0 = counters held at 0 and outputs idle
//   bus             line request / pixel FIFO interface (master side)
//   i_clr_underrun  clears o_underrun (a simultaneous set wins)
//   o_R/o_G/o_B     expanded pixel colour (registered)
//   o_HS/o_VS/o_DE  sync and data enable (registered, mutually aligned)
//   o_frame_start   1-clk pulse coincident with the first DE pixel of a frame
//   o_underrun      sticky: pixel missing at pop time or line request late
// ---------------------------------------------------------------------------
module vout_timing_reader #(
  parameter int SCR_SIZE_BIT = 10,
  parameter int H_ACTIVE     = 800,
  parameter int H_FP         = 40,
  parameter int H_SYNC       = 128,
  parameter int H_BP         = 88,
  parameter int V_ACTIVE     = 600,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 4,
  parameter int V_BP         = 23,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1,
  parameter int FETCH_LEAD   = 64
) (
  input  logic                       i_vo_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  vout_timing_reader_if.master       bus,
  input  logic                       i_clr_underrun,
  output logic [7:0]                 o_R,
  output logic [7:0]                 o_G,
  output logic [7:0]                 o_B,
  output logic                       o_HS,
  output logic                       o_VS,
  output logic                       o_DE,
  output logic                       o_frame_start,
  output logic                       o_underrun
);

  localparam int CW      = SCR_SIZE_BIT + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_FETCH = CW'(H_TOTAL - FETCH_LEAD);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Fetch FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // 4-bit component to 8 bits: full intensity replicates the nibble, half
  // intensity shifts it down one bit so the result stays below 0x80.
  function automatic logic [7:0] expand(input logic [3:0] c, input logic inten);
    expand = inten ? {c, c} : {1'b0, c, c[3:1]};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CW-1:0] h_cnt_q,    h_cnt_d;
  logic [CW-1:0] v_cnt_q,    v_cnt_d;
  logic [0:0]    state_q,    state_d;
  logic [CW-1:0] line_num_q, line_num_d;
  logic          en_q,       en_d;
  logic [7:0]    r_q,        r_d;
  logic [7:0]    g_q,        g_d;
  logic [7:0]    b_q,        b_d;
  logic          hs_q,       hs_d;
  logic          vs_q,       vs_d;
  logic          de_q,       de_d;
  logic          fs_q,       fs_d;
  logic          unr_q,      unr_d;

  logic          pop;
  logic [CW-1:0] next_line;
  logic          fetch_hit;
  logic          req_busy;
  logic          h_in_sync;
  logic          v_in_sync;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default at the top of the block,
  // so no path can leave one unassigned and infer a latch.
  always_comb begin
    pop       = i_enable && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    next_line = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    // Only a fetch point whose next line is active actually wants a request.
    fetch_hit = i_enable && (h_cnt_q == H_FETCH) && (next_line < V_ACT);
    // An ack arriving on the fetch clock frees the slot for the new request.
    req_busy  = (state_q == ST_REQ) && !bus.i_line_ack;
    h_in_sync = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    v_in_sync = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    state_d    = state_q;
    line_num_d = line_num_q;
    en_d       = i_enable;
    unr_d      = unr_q;

    if (!i_enable) begin
      h_cnt_d    = '0;
      v_cnt_d    = '0;
      state_d    = ST_IDLE;
      line_num_d = '0;
    end else begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end

      // Coming out of disable, line 0 is already being displayed, so fetch
      // it straight away instead of waiting for the previous line's fetch
      // point, which never happened.
      if (!en_q) begin
        state_d    = ST_REQ;
        line_num_d = '0;
      end else if (fetch_hit && !req_busy) begin
        state_d    = ST_REQ;
        line_num_d = next_line;
      end else if ((state_q == ST_REQ) && bus.i_line_ack) begin
        state_d = ST_IDLE;
      end
    end

    // Clear first so that a same-clock set overrides it.
    if (i_clr_underrun) begin
      unr_d = 1'b0;
    end
    if ((pop && !bus.i_pxl_valid) || (fetch_hit && req_busy)) begin
      unr_d = 1'b1;
    end

    // Video outputs: one register stage from the counters. With i_enable low
    // these collapse to their idle values on their own.
    de_d = pop;
    hs_d = (i_enable && h_in_sync) ? HS_POL : !HS_POL;
    vs_d = (i_enable && v_in_sync) ? VS_POL : !VS_POL;
    fs_d = i_enable && (h_cnt_q == '0) && (v_cnt_q == '0);

    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (pop && bus.i_pxl_valid) begin
      r_d = expand(bus.i_pxl_data[12:9], bus.i_pxl_data[0]);
      g_d = expand(bus.i_pxl_data[8:5],  bus.i_pxl_data[0]);
      b_d = expand(bus.i_pxl_data[4:1],  bus.i_pxl_data[0]);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments only, so every flop samples the values
  // from before the edge regardless of statement order.
  always_ff @(posedge i_vo_clk or posedge i_reset) begin
    if (i_reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      state_q    <= ST_IDLE;
      line_num_q <= '0;
      en_q       <= 1'b0;
      r_q        <= 8'h00;
      g_q        <= 8'h00;
      b_q        <= 8'h00;
      hs_q       <= !HS_POL;
      vs_q       <= !VS_POL;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      state_q    <= state_d;
      line_num_q <= line_num_d;
      en_q       <= en_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      unr_q      <= unr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.o_line_req = (state_q == ST_REQ);
  assign bus.o_line_num = line_num_q;
  assign bus.o_pxl_rd   = pop;

  assign o_R           = r_q;
  assign o_G           = g_q;
  assign o_B           = b_q;
  assign o_HS          = hs_q;
  assign o_VS          = vs_q;
  assign o_DE          = de_q;
  assign o_frame_start = fs_q;
  assign o_underrun    = unr_q;

endmodule : vout_timing_reader
